ee357_pc_write_ctrl: RTL and testbench
======================================

// Module: ee357_pc_write_ctrl
// PURPOSE
//   PC write-enable generator for the multicycle CPU datapath.
//   Combines the unconditional PC write and the conditional branch write
//   (with optional condition inversion for BEQ/BNE-style pairs) into one PC-register enable.
//   Sits between the control FSM and the PC register.
//   Also provides a registered copy of the enable and optional event counters.
// PARAMETERS
//   CNT_WIDTH   16   width of each statistics counter (used only with PC_WRITE_STATS_EN)
// PORTS
//   clk         in   1          system clock, rising edge
//   rst_n       in   1          reset, synchronous, active-low
//   pcw         in   1          unconditional PC write request from control FSM
//   pcwcond     in   1          conditional PC write request (branch state)
//   cond        in   1          ALU condition flag (e.g. zero)
//   inv_cond    in   1          1 = branch on NOT cond; 0 = branch on cond
//   w           out  1          PC register write enable (combinational)
//   w_q         out  1          w registered one cycle
//   br_taken    out  1          combinational: conditional write fired, pcw=0
//   uncond_cnt  out  CNT_WIDTH  count of cycles with pcw=1 (macro only)
//   taken_cnt   out  CNT_WIDTH  count of cycles with br_taken=1 (macro only)
//   nottkn_cnt  out  CNT_WIDTH  count of cycles with pcwcond=1 and eff_cond=0 (macro only)
// BEHAVIOUR
//   - Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
//   - eff_cond = cond XOR inv_cond.
//   - w = pcw OR (pcwcond AND eff_cond). The path is purely combinational, with zero latency.
//     w does not depend on clk or rst_n and is valid even while reset is held.
//     With all inputs driven, w is never X or Z.
//   - br_taken = pcwcond AND eff_cond AND NOT pcw.
//   - pcw=1 dominates: w=1 regardless of pcwcond, cond and inv_cond.
//   - pcwcond=0 and pcw=0: w=0 regardless of cond and inv_cond.
//   - inv_cond is ignored when pcwcond=0.
//   - w_q: on each rising clk edge, w_q <= (rst_n==0) ? 0 : w.
//     The reset value is 0. A reset asserted mid-operation clears w_q at the next edge.
//   - Counters, with PC_WRITE_STATS_EN defined:
//     - rst_n=0 at an edge clears all counters to 0.
//     - Otherwise each counter increments by 1 on each edge where its event is 1.
//     - Counters saturate at all-ones and do not wrap.
//     - Simultaneous events update their counters independently in the same cycle.
//     - pcw=1 with pcwcond=1 counts only uncond_cnt.
// CONFIGURATION
//   PC_WRITE_STATS_EN defined:
//     - uncond_cnt, taken_cnt and nottkn_cnt are implemented per BEHAVIOUR.
//   PC_WRITE_STATS_EN undefined:
//     - The counter ports remain on the interface and are tied to constant 0.
//     - No counter flops are built.
//     - w, w_q and br_taken are identical in both builds.
// TESTING
//   1. pcw=0, pcwcond=0, cond=0, inv_cond=0 -> w=0, br_taken=0.
//   2. pcw=1, others 0 -> w=1. pcw=1, pcwcond=1, cond=1, inv_cond=1 -> w=1, br_taken=0.
//   3. pcw=0, pcwcond=1: cond=1/inv=1 -> w=0; cond=1/inv=0 -> w=1;
//      cond=0/inv=0 -> w=0; cond=0/inv=1 -> w=1.
//   4. rst_n=0 for 2 edges with pcw=1 -> w=1 but w_q=0.
//      Release rst_n -> w_q=1 after the next edge.
//   5. With PC_WRITE_STATS_EN: after reset, apply 3 cycles pcw=1, then 2 taken cycles,
//      then 1 not-taken cycle -> uncond_cnt=3, taken_cnt=2, nottkn_cnt=1.
//   6. With PC_WRITE_STATS_EN and CNT_WIDTH=4: 20 taken cycles -> taken_cnt=15 (saturated).

Source files
------------

// File: rtl/ee357_pc_write_ctrl.sv
// ---------------------------------------------------------------------------
// ee357_pc_write_ctrl
//   PC write-enable generator for the multicycle CPU datapath. It sits between
//   the control FSM and the PC register. It merges the unconditional PC write
//   with the conditional branch write into one enable. The branch condition
//   can be inverted so that BEQ/BNE-style pairs share one ALU flag.
//   The block also provides a registered copy of the enable. When the build
//   macro below is defined, it adds saturating event counters.
//
// Build option
//   PC_WRITE_STATS_EN  defined   : uncond_cnt / taken_cnt / nottkn_cnt count events
//                      undefined : counter ports are tied to 0 and no counter flops exist
//
// Parameters
//   CNT_WIDTH   width of each statistics counter
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous reset, active-low
//   pcw         in   unconditional PC write request
//   pcwcond     in   conditional PC write request (branch state)
//   cond        in   ALU condition flag (e.g. zero)
//   inv_cond    in   1 = branch on NOT cond
//   w           out  PC register write enable (combinational)
//   w_q         out  w registered one cycle, cleared by reset
//   br_taken    out  conditional write fired while pcw=0
//   uncond_cnt  out  cycles with pcw=1
//   taken_cnt   out  cycles with br_taken=1
//   nottkn_cnt  out  cycles with a branch request that was not taken
// ---------------------------------------------------------------------------

// Saturating up-counter. It holds at all-ones instead of wrapping, so a long
// run cannot alias back to a small count.
module ee357_pc_write_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

module ee357_pc_write_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pcw,
    input  logic                 pcwcond,
    input  logic                 cond,
    input  logic                 inv_cond,
    output logic                 w,
    output logic                 w_q,
    output logic                 br_taken,
    output logic [CNT_WIDTH-1:0] uncond_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt,
    output logic [CNT_WIDTH-1:0] nottkn_cnt
);

    logic eff_cond;
    logic w_d;

    // The enable path is purely combinational. It is independent of clk and
    // rst_n, so the PC can still be written while reset is held.
    always_comb begin
        eff_cond = cond ^ inv_cond;
        w        = pcw | (pcwcond & eff_cond);
        br_taken = pcwcond & eff_cond & ~pcw;
        w_d      = w;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q <= 1'b0;
        end else begin
            w_q <= w_d;
        end
    end

`ifdef PC_WRITE_STATS_EN
    logic nottkn_evt;

    // An unconditional write overrides the branch. A cycle with pcw=1 is
    // therefore attributed only to uncond_cnt, even when a branch request is
    // present and would not have been taken.
    always_comb begin
        nottkn_evt = pcwcond & ~eff_cond & ~pcw;
    end

    ee357_pc_write_sat_cnt #(.W(CNT_WIDTH)) u_uncond_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pcw),
        .cnt   (uncond_cnt)
    );

    ee357_pc_write_sat_cnt #(.W(CNT_WIDTH)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_taken),
        .cnt   (taken_cnt)
    );

    ee357_pc_write_sat_cnt #(.W(CNT_WIDTH)) u_nottkn_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (nottkn_evt),
        .cnt   (nottkn_cnt)
    );
`else
    assign uncond_cnt = '0;
    assign taken_cnt  = '0;
    assign nottkn_cnt = '0;
`endif

endmodule

// File: tb/tb_ee357_pc_write_ctrl.sv
module tb_ee357_pc_write_ctrl;

    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pcw = 1'b0;
    logic          pcwcond = 1'b0;
    logic          cond = 1'b0;
    logic          inv_cond = 1'b0;
    logic          w;
    logic          w_q;
    logic          br_taken;
    logic [CW-1:0] uncond_cnt;
    logic [CW-1:0] taken_cnt;
    logic [CW-1:0] nottkn_cnt;

    ee357_pc_write_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pcw        (pcw),
        .pcwcond    (pcwcond),
        .cond       (cond),
        .inv_cond   (inv_cond),
        .w          (w),
        .w_q        (w_q),
        .br_taken   (br_taken),
        .uncond_cnt (uncond_cnt),
        .taken_cnt  (taken_cnt),
        .nottkn_cnt (nottkn_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard queues: the combinational expectations are {w, br_taken}.
    // The post-edge expectations are {w_q, uncond, taken, nottkn}.
    logic [1:0]      q_comb[$];
    logic [3*CW:0]   q_seq[$];

    // Reference model state.
    logic m_wq;
    int   m_u, m_t, m_n;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One cycle: drive the inputs at the negedge, check the combinational
    // outputs, then check the registered outputs just after the next posedge.
    task automatic step(input logic r, input logic p, input logic pc,
                        input logic c, input logic i);
        logic          ec, ew, eb;
        logic [1:0]    ecomb;
        logic [3*CW:0] eseq;
        @(negedge clk);
        rst_n = r; pcw = p; pcwcond = pc; cond = c; inv_cond = i;
        ec = c ^ i;
        ew = p | (pc & ec);
        eb = pc & ec & ~p;
        q_comb.push_back({ew, eb});
        if (!r) begin
            m_wq = 1'b0; m_u = 0; m_t = 0; m_n = 0;
        end else begin
            m_wq = ew;
            if (p && m_u < MAX) m_u++;
            if (eb && m_t < MAX) m_t++;
            if (pc && !ec && !p && m_n < MAX) m_n++;
        end
`ifdef PC_WRITE_STATS_EN
        q_seq.push_back({m_wq, m_u[CW-1:0], m_t[CW-1:0], m_n[CW-1:0]});
`else
        q_seq.push_back({m_wq, {(3*CW){1'b0}}});
`endif
        #1;
        ecomb = q_comb.pop_front();
        check("w", {15'd0, w}, {15'd0, ecomb[1]});
        check("br_taken", {15'd0, br_taken}, {15'd0, ecomb[0]});
        @(posedge clk);
        #1;
        eseq = q_seq.pop_front();
        check("w_q", {15'd0, w_q}, {15'd0, eseq[3*CW]});
        check("uncond_cnt", {12'd0, uncond_cnt}, {12'd0, eseq[3*CW-1:2*CW]});
        check("taken_cnt", {12'd0, taken_cnt}, {12'd0, eseq[2*CW-1:CW]});
        check("nottkn_cnt", {12'd0, nottkn_cnt}, {12'd0, eseq[CW-1:0]});
    endtask

    initial begin
        // Reset state. pcw=1 while in reset: w=1 but w_q must stay 0.
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);   // release: w_q goes to 1 after this edge

        // Basic truth table.
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1);   // inv_cond ignored while pcwcond=0
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 1);   // pcw dominates, br_taken=0
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 1, 1);
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 1);

        // Counter sequence: 3 unconditional, 2 taken, 1 not taken.
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 0, 1);
        step(1, 0, 1, 0, 0);
`ifdef PC_WRITE_STATS_EN
        check("seq_uncond", {12'd0, uncond_cnt}, 16'd3);
        check("seq_taken", {12'd0, taken_cnt}, 16'd2);
        check("seq_nottkn", {12'd0, nottkn_cnt}, 16'd1);
`else
        check("seq_uncond_off", {12'd0, uncond_cnt}, 16'd0);
`endif

        // Mid-operation reset clears w_q and the counters.
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Saturation: 20 taken cycles, then 20 mixed cycles.
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(1, 0, 1, 1, 0);
`ifdef PC_WRITE_STATS_EN
        check("taken_sat", {12'd0, taken_cnt}, 16'd15);
`endif
        for (int k = 0; k < 20; k++) begin
            step(1, 1, 1, 0, 0);
            step(1, 0, 1, 0, 0);
        end

        // Random traffic with occasional resets.
        for (int k = 0; k < 60; k++) begin
            step(logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
